uart_echo_tester: RTL and testbench
===================================

UART_ECHO_TESTER -- requirements
Module: uart_echo_tester

Interface
REQ-001 SHALL provide parameter NUM_BYTES, default 256, number of pattern bytes sent per test run (1..65535).
REQ-002 SHALL provide parameter TIMEOUT_CLKS, default 20000, clocks to wait for each echo before declaring a timeout (>= 2).
REQ-003 SHALL have i_Clock  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have i_Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have i_Start  input  1  single-cycle request to begin a test run.
REQ-006 SHALL have o_Tx_DV  output  1  one-cycle byte-valid strobe to the UART transmitter.
REQ-007 SHALL have o_Tx_Byte  output  8  byte presented to the transmitter, stable from o_Tx_DV until i_Tx_Done.
REQ-008 SHALL have i_Tx_Active  input  1  transmitter busy.
REQ-009 SHALL have i_Tx_Done  input  1  transmitter one-cycle completion pulse.
REQ-010 SHALL have i_Rx_DV  input  1  receiver one-cycle byte-valid pulse.
REQ-011 SHALL have i_Rx_Byte  input  8  received byte, valid with i_Rx_DV.
REQ-012 SHALL have o_Busy  output  1  high from accepted start until run completion.
REQ-013 SHALL have o_Done  output  1  one-cycle pulse at run completion.
REQ-014 SHALL have o_Pass  output  1  high after a run with zero mismatches and zero timeouts; held until next start.
REQ-015 SHALL have o_Err_Count  output  16  mismatched echo count, saturating at 16'hFFFF.
REQ-016 SHALL have o_Timeout_Count  output  16  missing echo count, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT, NEXT, DONE.
REQ-018 IDLE: i_Start high -> clear both counters, clear o_Pass, load LFSR with 8'h01, clear byte index, go to SEND; other inputs ignored.
REQ-019 i_Start while not in IDLE SHALL be ignored.
REQ-020 SEND: when i_Tx_Active low, drive o_Tx_Byte = LFSR and assert o_Tx_DV for exactly one cycle, clear the timeout counter and the tx-done/echo flags, go to WAIT. While i_Tx_Active is high, remain in SEND with o_Tx_DV low.
REQ-021 LFSR next value SHALL be {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; sequence from seed: 01, 02, 04, 08, 11, 23, ...
REQ-022 WAIT: set tx-done flag on i_Tx_Done; on first i_Rx_DV, set echo flag and compare i_Rx_Byte against the sent byte; mismatch -> o_Err_Count +1 (saturating).
REQ-023 In WAIT, i_Tx_Done and i_Rx_DV SHALL be accepted in either order or in the same cycle; i_Rx_DV after the echo flag is already set SHALL be ignored.
REQ-024 WAIT SHALL go to NEXT once both flags are set.
REQ-025 WAIT timeout counter SHALL increment every cycle; on reaching TIMEOUT_CLKS-1 without the echo flag set -> o_Timeout_Count +1 (saturating), go to NEXT (tx-done flag not required).
REQ-026 NEXT: advance LFSR, increment byte index; if index reaches NUM_BYTES -> DONE, else -> SEND.
REQ-027 DONE: pulse o_Done one cycle; set o_Pass = (o_Err_Count==0 && o_Timeout_Count==0); return to IDLE.
REQ-028 o_Busy SHALL be high in SEND, WAIT, NEXT; low in IDLE and DONE.
REQ-029 i_Rx_DV in IDLE, SEND, NEXT, DONE SHALL be ignored.
REQ-030 Counters and o_Pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-031 i_Reset high SHALL immediately force state IDLE, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Done=0, o_Pass=0, o_Err_Count=0, o_Timeout_Count=0, LFSR=8'h01, index=0, independent of clock.
REQ-032 Reset asserted mid-run SHALL abort the run without an o_Done pulse; first start after release SHALL begin from seed 8'h01.

Verification
REQ-033 NUM_BYTES=4, ideal loopback model: start -> o_Tx_Byte sequence 01,02,04,08; o_Done one pulse; o_Pass=1; both counts 0.
REQ-034 NUM_BYTES=4, model corrupts 3rd echo (04 -> 05): o_Err_Count=1, o_Timeout_Count=0, o_Pass=0.
REQ-035 NUM_BYTES=2, TIMEOUT_CLKS=50, no echoes: each byte advances after 50 clocks in WAIT; o_Timeout_Count=2, o_Pass=0.
REQ-036 Echo i_Rx_DV before i_Tx_Done, and same-cycle i_Rx_DV+i_Tx_Done: both accepted, next o_Tx_DV only after both; duplicate i_Rx_DV ignored.
REQ-037 i_Tx_Active held high 10 cycles at SEND entry: o_Tx_DV stays low, fires one cycle after i_Tx_Active falls; i_Start during run ignored.
REQ-038 i_Reset asserted during WAIT of byte 2: all outputs 0 asynchronously, no o_Done; new run's first byte 01.

Source files
------------

// File: rtl/uart_echo_tester_if.sv
// UART side of the echo tester: transmit request/status and receive strobe.
// The master modport is the tester, the slave modport is the UART pair.
interface uart_echo_tester_if;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;

  modport master (
    output o_Tx_DV,
    output o_Tx_Byte,
    input  i_Tx_Active,
    input  i_Tx_Done,
    input  i_Rx_DV,
    input  i_Rx_Byte
  );

  modport slave (
    input  o_Tx_DV,
    input  o_Tx_Byte,
    output i_Tx_Active,
    output i_Tx_Done,
    output i_Rx_DV,
    output i_Rx_Byte
  );
endinterface

// File: rtl/uart_echo_tester.sv
// UART loopback tester: sends an LFSR byte pattern and checks each echo.
// Counts mismatched and missing echoes and reports pass/fail per run.
module uart_echo_tester #(
  parameter int NUM_BYTES    = 256,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Start,
  uart_echo_tester_if.master        uart,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic                      o_Pass,
  output logic [15:0]               o_Err_Count,
  output logic [15:0]               o_Timeout_Count
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]   I_LAST = 16'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    NEXT,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nx;
  logic [15:0]   idx;
  logic [TW-1:0] tcnt;
  logic          tx_seen;
  logic          echo_seen;
  logic          mismatch;

  // next pattern byte and echo compare against the byte on the wire
  always_comb begin
    lfsr_nx  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    mismatch = uart.i_Rx_Byte != uart.o_Tx_Byte;
  end

  // run sequencer: send, await tx-done and echo, count errors/timeouts
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state           <= IDLE;
      uart.o_Tx_DV    <= 1'b0;
      uart.o_Tx_Byte  <= 8'h00;
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
      o_Pass          <= 1'b0;
      o_Err_Count     <= 16'h0000;
      o_Timeout_Count <= 16'h0000;
      lfsr            <= 8'h01;
      idx             <= 16'h0000;
      tcnt            <= '0;
      tx_seen         <= 1'b0;
      echo_seen       <= 1'b0;
    end else begin
      uart.o_Tx_DV <= 1'b0;
      o_Done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_Start) begin
            o_Err_Count     <= 16'h0000;
            o_Timeout_Count <= 16'h0000;
            o_Pass          <= 1'b0;
            lfsr            <= 8'h01;
            idx             <= 16'h0000;
            o_Busy          <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          if (!uart.i_Tx_Active) begin
            uart.o_Tx_Byte <= lfsr;
            uart.o_Tx_DV   <= 1'b1;
            tcnt           <= '0;
            tx_seen        <= 1'b0;
            echo_seen      <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (uart.i_Tx_Done) tx_seen <= 1'b1;
          if (uart.i_Rx_DV && !echo_seen) begin
            echo_seen <= 1'b1;
            if (mismatch && o_Err_Count != 16'hFFFF)
              o_Err_Count <= o_Err_Count + 16'd1;
          end
          if (tx_seen && echo_seen) begin
            state <= NEXT;
          end else if (tcnt == T_LAST) begin
            // an echo arriving on the last cycle still counts as received
            if (!echo_seen && !uart.i_Rx_DV) begin
              if (o_Timeout_Count != 16'hFFFF)
                o_Timeout_Count <= o_Timeout_Count + 16'd1;
              state <= NEXT;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        NEXT: begin
          lfsr <= lfsr_nx;
          idx  <= idx + 16'd1;
          if (idx == I_LAST) begin
            o_Busy <= 1'b0;
            o_Done <= 1'b1;
            o_Pass <= (o_Err_Count == 16'h0000) &&
                      (o_Timeout_Count == 16'h0000);
            state  <= DONE;
          end else begin
            state <= SEND;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: emulated UART loopback with table-driven
// and randomized runs checked against a pattern/count reference model.
module tb_uart_echo_tester;
  localparam int NB = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] to_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  exp_seq [NB];

  uart_echo_tester_if uart ();

  uart_echo_tester #(.NUM_BYTES(NB), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Start        (start),
    .uart           (uart.master),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_Pass         (pass),
    .o_Err_Count    (err_cnt),
    .o_Timeout_Count(to_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] drop;
    logic [3:0] corrupt;
    int         order;
    int         exp_err;
    int         exp_to;
    bit         exp_pass;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    uart.i_Rx_DV   = 1'b1;
    uart.i_Rx_Byte = b;
    tick();
    uart.i_Rx_DV   = 1'b0;
  endtask

  task automatic pulse_done(input logic [7:0] sent);
    check("tx_byte_stable", uart.o_Tx_Byte, sent);
    uart.i_Tx_Done   = 1'b1;
    uart.i_Tx_Active = 1'b0;
    tick();
    uart.i_Tx_Done   = 1'b0;
  endtask

  task automatic gap_check(input int g);
    int bad;
    bad = 0;
    for (int i = 0; i < g; i++) begin
      if (uart.o_Tx_DV) bad++;
      tick();
    end
    check("no_dv_before_both", bad, 0);
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (uart.o_Tx_DV) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_case(input logic [3:0] drop, input logic [3:0] corrupt,
                          input int order, input bit hold,
                          input int ee, input int et, input bit ep);
    bit         ok;
    int         bad;
    int         t0;
    logic [7:0] sent;
    logic [7:0] eb;
    t0 = 0;
    if (hold) uart.i_Tx_Active = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (hold) begin
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (uart.o_Tx_DV) bad++;
        start = (i == 4);
        tick();
      end
      start = 1'b0;
      check("dv_held_by_active", bad, 0);
      uart.i_Tx_Active = 1'b0;
      tick();
      check("dv_after_active_fall", uart.o_Tx_DV, 1);
    end
    for (int k = 0; k < NB; k++) begin
      wait_dv(ok);
      check("dv_seen", ok, 1);
      if (!ok) return;
      if (k > 0 && drop[k-1])
        check("timeout_spacing", (cyc - t0 > TO) && (cyc - t0 <= TO + 4), 1);
      t0   = cyc;
      sent = uart.o_Tx_Byte;
      check("tx_byte", sent, exp_seq[k]);
      eb = corrupt[k] ? (exp_seq[k] ^ 8'h01) : exp_seq[k];
      uart.i_Tx_Active = 1'b1;
      tick();
      check("dv_one_cycle", uart.o_Tx_DV, 0);
      if (k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      if (drop[k]) begin
        pulse_done(exp_seq[k]);
      end else begin
        case (order)
          0: begin
            pulse_done(exp_seq[k]);
            gap_check($urandom_range(1, 4));
            pulse_rx(eb);
          end
          1: begin
            pulse_rx(eb);
            gap_check($urandom_range(1, 4));
            pulse_done(exp_seq[k]);
          end
          2: begin
            check("tx_byte_stable", uart.o_Tx_Byte, exp_seq[k]);
            uart.i_Rx_DV     = 1'b1;
            uart.i_Rx_Byte   = eb;
            uart.i_Tx_Done   = 1'b1;
            uart.i_Tx_Active = 1'b0;
            tick();
            uart.i_Rx_DV     = 1'b0;
            uart.i_Tx_Done   = 1'b0;
          end
          default: begin
            pulse_rx(eb);
            pulse_rx(~eb);
            pulse_done(exp_seq[k]);
          end
        endcase
      end
    end
    wait_done(ok);
    check("done_seen", ok, 1);
    if (drop[NB-1])
      check("timeout_spacing", (cyc - t0 > TO) && (cyc - t0 <= TO + 4), 1);
    check("pass", pass, ep);
    check("err_count", err_cnt, ee);
    check("timeout_count", to_cnt, et);
    check("busy_at_done", busy, 0);
    tick();
    check("done_one_pulse", done, 0);
    tick();
    check("pass_held", pass, ep);
  endtask

  initial begin
    logic [7:0] l;
    bit         ok;
    int         bad;
    logic [3:0] d;
    logic [3:0] c;
    int         o;

    l = 8'h01;
    for (int i = 0; i < NB; i++) begin
      exp_seq[i] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end

    vt[0] = '{4'b0000, 4'b0000, 0, 0, 0, 1'b1};
    vt[1] = '{4'b0000, 4'b0100, 0, 1, 0, 1'b0};
    vt[2] = '{4'b0000, 4'b0000, 1, 0, 0, 1'b1};
    vt[3] = '{4'b0000, 4'b0000, 2, 0, 0, 1'b1};
    vt[4] = '{4'b0000, 4'b0000, 3, 0, 0, 1'b1};
    vt[5] = '{4'b1111, 4'b0000, 0, 0, 4, 1'b0};
    vt[6] = '{4'b0011, 4'b1010, 1, 1, 2, 1'b0};

    uart.i_Tx_Active = 1'b0;
    uart.i_Tx_Done   = 1'b0;
    uart.i_Rx_DV     = 1'b0;
    uart.i_Rx_Byte   = 8'h00;

    #2 rst = 1'b1;
    #1;
    check("rst_tx_dv", uart.o_Tx_DV, 0);
    check("rst_tx_byte", uart.o_Tx_Byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_to", to_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++)
      run_case(vt[v].drop, vt[v].corrupt, vt[v].order, 1'b0,
               vt[v].exp_err, vt[v].exp_to, vt[v].exp_pass);

    run_case(4'b0000, 4'b0000, 0, 1'b1, 0, 0, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dv(ok);
    check("mid_dv1", ok, 1);
    uart.i_Tx_Active = 1'b1;
    tick();
    pulse_done(exp_seq[0]);
    pulse_rx(exp_seq[0] ^ 8'h01);
    wait_dv(ok);
    check("mid_dv2", ok, 1);
    uart.i_Tx_Active = 1'b1;
    tick();
    check("mid_err_before_rst", err_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_async",
          {uart.o_Tx_DV, uart.o_Tx_Byte, busy, done, pass, err_cnt, to_cnt}, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) bad++;
    end
    rst = 1'b0;
    uart.i_Tx_Active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) bad++;
    end
    check("no_done_after_abort", bad, 0);

    run_case(4'b0000, 4'b0000, 0, 1'b0, 0, 0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      d = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      c = 4'($urandom);
      o = $urandom_range(0, 3);
      run_case(d, c, o, 1'b0, $countones(c & ~d), $countones(d),
               (c & ~d) == 4'b0000 && d == 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
